// File: rtl/comparator_4bit.sv
// Registered 4-bit magnitude comparator with 74x85-style cascade in/out.
// Optional macro COMPARATOR_4BIT_CASCADE_ERR_EN adds a registered cascade_err flag.
module comparator_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             LTin,
  input  logic             EQIn,
  input  logic             GTin,
  output logic             LTout,
  output logic             EQout,
  output logic             GTout,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B
`ifdef COMPARATOR_4BIT_CASCADE_ERR_EN
  ,
  output logic             cascade_err
`endif
);

  logic lt_d, eq_d, gt_d;
  logic lt_q, eq_q, gt_q;
  logic casc_bad;

  always_comb begin
    lt_d     = 1'b0;
    eq_d     = 1'b0;
    gt_d     = 1'b0;
    casc_bad = 1'b0;
    if (A > B) begin
      gt_d = 1'b1;
    end else if (A < B) begin
      lt_d = 1'b1;
    end else begin
      // Invalid cascade combinations fall back to EQ so the result stays one-hot.
      unique case ({LTin, EQIn, GTin})
        3'b100:  lt_d = 1'b1;
        3'b010:  eq_d = 1'b1;
        3'b001:  gt_d = 1'b1;
        default: begin
          eq_d     = 1'b1;
          casc_bad = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lt_q <= 1'b0;
      eq_q <= 1'b1;
      gt_q <= 1'b0;
    end else begin
      lt_q <= lt_d;
      eq_q <= eq_d;
      gt_q <= gt_d;
    end
  end

  assign LTout = lt_q;
  assign EQout = eq_q;
  assign GTout = gt_q;

`ifdef COMPARATOR_4BIT_CASCADE_ERR_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= casc_bad;
    end
  end

  assign cascade_err = err_q;
`else
  logic unused_casc_bad;
  assign unused_casc_bad = casc_bad;
`endif

endmodule

// File: tb/tb_comparator_4bit.sv
// Self-checking bench for comparator_4bit: cycle model plus directed literal vectors.
module tb_comparator_4bit;

  logic       clk;
  logic       rst_n;
  logic       LTin, EQIn, GTin;
  logic       LTout, EQout, GTout;
  logic [3:0] A, B;
`ifdef COMPARATOR_4BIT_CASCADE_ERR_EN
  logic       cascade_err;
`endif

  int errors = 0;
  int checks = 0;

  comparator_4bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .LTin  (LTin),
    .EQIn  (EQIn),
    .GTin  (GTin),
    .LTout (LTout),
    .EQout (EQout),
    .GTout (GTout),
    .A     (A),
    .B     (B)
`ifdef COMPARATOR_4BIT_CASCADE_ERR_EN
    ,
    .cascade_err (cascade_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {LT,EQ,GT} computed from the comparison rules with plain integers.
  function automatic logic [2:0] model_out(input logic rn, input int a, input int b,
                                           input int l, input int e, input int g);
    if (!rn) return 3'b010;
    if (a > b) return 3'b001;
    if (a < b) return 3'b100;
    if (l + e + g != 1) return 3'b010;
    return {l[0], e[0], g[0]};
  endfunction

  function automatic logic model_err(input logic rn, input int a, input int b,
                                     input int l, input int e, input int g);
    return rn && (a == b) && (l + e + g != 1);
  endfunction

  task automatic chk3(input string name, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got {LT,EQ,GT}=%b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Model registers sampled on the same edge as the DUT.
  logic [2:0] exp_q;
  logic       exp_err_q;
  logic       model_valid = 1'b0;

  always @(posedge clk) begin
    exp_q       <= model_out(rst_n, int'(A), int'(B), int'(LTin), int'(EQIn), int'(GTin));
    exp_err_q   <= model_err(rst_n, int'(A), int'(B), int'(LTin), int'(EQIn), int'(GTin));
    model_valid <= 1'b1;
  end

  always @(negedge clk) begin
    if (model_valid) begin
      chk3("model", {LTout, EQout, GTout}, exp_q);
      chk1("onehot", $onehot({LTout, EQout, GTout}), 1'b1);
`ifdef COMPARATOR_4BIT_CASCADE_ERR_EN
      chk1("cascade_err", cascade_err, exp_err_q);
`endif
    end
  end

  // Drive one vector, then after one edge check the hand-computed expectation.
  task automatic vec(input string name, input logic [3:0] a, input logic [3:0] b,
                     input logic l, input logic e, input logic g,
                     input logic [2:0] exp, input logic exp_err);
    A = a; B = b; LTin = l; EQIn = e; GTin = g;
    @(negedge clk);
    chk3(name, {LTout, EQout, GTout}, exp);
`ifdef COMPARATOR_4BIT_CASCADE_ERR_EN
    chk1({name, "_err"}, cascade_err, exp_err);
`else
    if (exp_err) begin end
`endif
  endtask

  initial begin
    rst_n = 1'b0; A = 4'd9; B = 4'd2; LTin = 1'b0; EQIn = 1'b1; GTin = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk3("reset", {LTout, EQout, GTout}, 3'b010);
    rst_n = 1'b1;

    vec("eq_0000",     4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 3'b010, 1'b0);
    vec("eq_1100",     4'b1100, 4'b1100, 1'b0, 1'b1, 1'b0, 3'b010, 1'b0);
    vec("lt_0100",     4'b0100, 4'b1100, 1'b0, 1'b1, 1'b0, 3'b100, 1'b0);
    vec("lt_0101",     4'b0101, 4'b1000, 1'b0, 1'b1, 1'b0, 3'b100, 1'b0);
    vec("gt_1111_1100", 4'b1111, 4'b1100, 1'b0, 1'b1, 1'b0, 3'b001, 1'b0);
    vec("gt_1111_0111", 4'b1111, 4'b0111, 1'b0, 1'b1, 1'b0, 3'b001, 1'b0);
    vec("eq_1111",     4'b1111, 4'b1111, 1'b0, 1'b1, 1'b0, 3'b010, 1'b0);
    vec("gt_15_0",     4'd15,   4'd0,    1'b0, 1'b1, 1'b0, 3'b001, 1'b0);
    vec("lt_0_15",     4'd0,    4'd15,   1'b0, 1'b1, 1'b0, 3'b100, 1'b0);
    vec("casc_gt",     4'b1010, 4'b1010, 1'b0, 1'b0, 1'b1, 3'b001, 1'b0);
    vec("casc_lt",     4'b1010, 4'b1010, 1'b1, 1'b0, 1'b0, 3'b100, 1'b0);
    vec("casc_ltgt",   4'b1010, 4'b1010, 1'b1, 1'b0, 1'b1, 3'b010, 1'b1);
    vec("casc_none",   4'b1010, 4'b1010, 1'b0, 1'b0, 1'b0, 3'b010, 1'b1);
    vec("casc_all",    4'b1010, 4'b1010, 1'b1, 1'b1, 1'b1, 3'b010, 1'b1);
    vec("casc_ign",    4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0, 3'b001, 1'b0);
    vec("casc_ign_lt", 4'b0110, 4'b0111, 1'b0, 1'b0, 1'b1, 3'b100, 1'b0);

    // Back-to-back changes: the model process checks each 1-edge lag.
    for (int i = 0; i < 40; i++) begin
      A = 4'($urandom_range(0, 15));
      B = (i % 3 == 0) ? A : 4'($urandom_range(0, 15));
      LTin = 1'($urandom_range(0, 1));
      EQIn = 1'($urandom_range(0, 1));
      GTin = 1'($urandom_range(0, 1));
      @(negedge clk);
    end

    // Reset for one edge while A>B, then release.
    A = 4'd7; B = 4'd3; LTin = 1'b0; EQIn = 1'b1; GTin = 1'b0;
    @(negedge clk);
    chk3("pre_rst_gt", {LTout, EQout, GTout}, 3'b001);
    rst_n = 1'b0;
    @(negedge clk);
    chk3("mid_rst", {LTout, EQout, GTout}, 3'b010);
`ifdef COMPARATOR_4BIT_CASCADE_ERR_EN
    chk1("mid_rst_err", cascade_err, 1'b0);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    chk3("post_rst_gt", {LTout, EQout, GTout}, 3'b001);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
